// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream_if
// Brief    : FIFO read port plus valid/ready output stream of fifo_rd_stream.
// Revision : 1.0
// ============================================================================
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_r_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        input  fifo_empty, fifo_rdata, out_ready,
        output fifo_r_en, out_valid, out_data
    );

    modport slave (
        output fifo_empty, fifo_rdata, out_ready,
        input  fifo_r_en, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Brief    : Pops an async FIFO and drives a valid/ready stream via a 2-deep skid buffer.
// Revision : 1.0
// ============================================================================
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                 rclk,
    input  wire logic                 rrst_n,
    input  wire logic                 flush,
    fifo_rd_stream_if.master          bus,
    output logic [CNT_WIDTH-1:0]      xfer_count
);
    // state value doubles as buffer occupancy
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [CNT_WIDTH-1:0]  r_xfer;
    logic                  w_pop;
    logic                  w_deq;
    logic                  w_out_valid;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= S0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S0;
        end else begin
            case (r_state)
                S0:      if (w_pop) w_state_nxt = S1;
                S1: begin
                    if (w_pop && !w_deq)      w_state_nxt = S2;
                    else if (!w_pop && w_deq) w_state_nxt = S0;
                end
                S2:      if (w_deq) w_state_nxt = S1;
                default: w_state_nxt = S0;
            endcase
        end
    end

    // Pop request never looks at out_ready, so no ready-to-r_en comb path.
    always_comb begin
        w_out_valid = (r_state != S0);
        w_pop       = !bus.fifo_empty && (r_state != S2) && !flush && rrst_n;
        w_deq       = w_out_valid && bus.out_ready;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (!flush) begin
            case (r_state)
                S0: if (w_pop) r_head <= bus.fifo_rdata;
                S1: begin
                    if (w_pop && w_deq)  r_head <= bus.fifo_rdata;
                    if (w_pop && !w_deq) r_tail <= bus.fifo_rdata;
                end
                S2: if (w_deq) r_head <= r_tail;
                default: ;
            endcase
        end
    end

    // A handshake coinciding with flush still counts as a transfer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_xfer <= '0;
        end else if (w_deq) begin
            r_xfer <= r_xfer + 1'b1;
        end
    end

    assign bus.fifo_r_en = w_pop;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_head;
    assign xfer_count    = r_xfer;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_stream
// Brief    : Self-checking bench for fifo_rd_stream with a FIFO model and scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fifo_rd_stream;
    logic        rclk = 1'b0;
    logic        rrst_n;
    logic        flush;
    logic        flush4;
    logic [15:0] xfer_count;
    logic [3:0]  xfer4;

    fifo_rd_stream_if #(.DATA_WIDTH(8)) bus  ();
    fifo_rd_stream_if #(.DATA_WIDTH(8)) bus4 ();

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .flush(flush), .bus(bus), .xfer_count(xfer_count)
    );

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .flush(flush4), .bus(bus4), .xfer_count(xfer4)
    );

    always #5 rclk = ~rclk;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         pops     = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       hold_empty = 1'b0;
    logic       prev_hold  = 1'b0;
    logic [7:0] prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        bus.fifo_empty = hold_empty || (fifo_q.size() == 0);
        bus.fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    // FIFO model, scoreboard and per-cycle invariants, all sampled before the edge settles
    always @(posedge rclk) begin
        if (rrst_n) begin
            check("ren_illegal", {31'd0, bus.fifo_r_en && (bus.fifo_empty || dut.r_state == 2'd2)}, 32'd0);
            if (prev_hold) begin
                check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                check("hold_data", {24'd0, bus.out_data}, {24'd0, prev_data});
            end
            prev_hold = bus.out_valid && !bus.out_ready && !flush;
            prev_data = bus.out_data;
            if (flush) begin
                exp_q.delete();
            end else if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else check("sb_data", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
            end
            if (bus.fifo_r_en && !bus.fifo_empty) begin
                exp_q.push_back(bus.fifo_rdata);
                void'(fifo_q.pop_front());
                pops++;
            end
        end else begin
            prev_hold = 1'b0;
        end
        #1 refresh();
    end

    int start;
    int cyc;
    int n4;

    initial begin
        rrst_n = 1'b1;
        flush = 1'b0;
        flush4 = 1'b0;
        bus.out_ready = 1'b0;
        bus4.out_ready = 1'b0;
        bus4.fifo_empty = 1'b1;
        bus4.fifo_rdata = 8'h00;
        fifo_q.push_back(8'h55);
        refresh();
        #1 rrst_n = 1'b0;
        repeat (2) tick();
        @(negedge rclk);
        check("rst_r_en", {31'd0, bus.fifo_r_en}, 32'd0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_xfer", {16'd0, xfer_count}, 32'd0);

        fifo_q.delete();
        refresh();
        tick();
        rrst_n = 1'b1;
        tick();
        @(negedge rclk);
        check("idle_r_en", {31'd0, bus.fifo_r_en}, 32'd0);
        check("idle_valid", {31'd0, bus.out_valid}, 32'd0);

        // streaming 0x01..0x08 with ready held high
        start = pops;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        bus.out_ready = 1'b1;
        tick();
        refresh();
        tick();
        @(negedge rclk);
        check("stream_first_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stream_first_data", {24'd0, bus.out_data}, 32'h01);
        repeat (7) tick();
        check("stream_pops", pops - start, 32'd8);
        repeat (2) tick();
        @(negedge rclk);
        check("stream_xfer", {16'd0, xfer_count}, 32'd8);
        check("stream_valid_end", {31'd0, bus.out_valid}, 32'd0);
        check("stream_sb_empty", exp_q.size(), 32'd0);

        // backpressure: only two words may be taken
        bus.out_ready = 1'b0;
        start = pops;
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'hA0 + 8'(i));
        refresh();
        repeat (4) tick();
        @(negedge rclk);
        check("bp_pops", pops - start, 32'd2);
        check("bp_state", {30'd0, dut.r_state}, 32'd2);
        check("bp_data", {24'd0, bus.out_data}, 32'hA0);
        check("bp_r_en", {31'd0, bus.fifo_r_en}, 32'd0);
        tick();
        bus.out_ready = 1'b1;
        repeat (8) tick();
        @(negedge rclk);
        check("bp_pops_all", pops - start, 32'd6);
        check("bp_xfer", {16'd0, xfer_count}, 32'd14);
        check("bp_sb_empty", exp_q.size(), 32'd0);

        // flush while full and a handshake is in flight
        bus.out_ready = 1'b0;
        start = pops;
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
        refresh();
        repeat (3) tick();
        flush = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge rclk);
        check("flush_r_en", {31'd0, bus.fifo_r_en}, 32'd0);
        tick();
        flush = 1'b0;
        @(negedge rclk);
        check("flush_pops", pops - start, 32'd2);
        check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_xfer", {16'd0, xfer_count}, 32'd15);
        tick();
        @(negedge rclk);
        check("flush_next_valid", {31'd0, bus.out_valid}, 32'd1);
        check("flush_next_data", {24'd0, bus.out_data}, 32'h33);
        repeat (3) tick();
        @(negedge rclk);
        check("flush_drain_xfer", {16'd0, xfer_count}, 32'd17);

        // random ready and random FIFO-empty gaps
        start = pops;
        for (int i = 0; i < 200; i++) fifo_q.push_back(8'($urandom));
        refresh();
        cyc = 0;
        while (((pops - start) < 200 || exp_q.size() != 0) && cyc < 3000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            hold_empty = ($urandom_range(0, 3) == 0);
            refresh();
            tick();
            cyc++;
        end
        hold_empty = 1'b0;
        refresh();
        check("rand_timeout", {31'd0, cyc < 3000}, 32'd1);
        check("rand_pops", pops - start, 32'd200);
        check("rand_xfer", {16'd0, xfer_count}, 32'd217);

        // 4-bit counter wraps after 16 transfers
        bus4.fifo_rdata = 8'h5A;
        bus4.fifo_empty = 1'b0;
        bus4.out_ready = 1'b1;
        n4 = 0;
        cyc = 0;
        while (n4 < 17 && cyc < 100) begin
            @(negedge rclk);
            if (bus4.out_valid && bus4.out_ready) n4++;
            tick();
            cyc++;
        end
        bus4.out_ready = 1'b0;
        bus4.fifo_empty = 1'b1;
        check("wrap_timeout", {31'd0, cyc < 100}, 32'd1);
        check("wrap_xfer", {28'd0, xfer4}, 32'd1);

        // asynchronous reset while full
        bus.out_ready = 1'b0;
        fifo_q.push_back(8'h66); fifo_q.push_back(8'h77); fifo_q.push_back(8'h88);
        refresh();
        repeat (3) tick();
        @(negedge rclk);
        check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        check("pre_rst_data", {24'd0, bus.out_data}, 32'h66);
        #1 rrst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_data", {24'd0, bus.out_data}, 32'd0);
        check("arst_xfer", {16'd0, xfer_count}, 32'd0);
        check("arst_r_en", {31'd0, bus.fifo_r_en}, 32'd0);
        check("arst_state", {30'd0, dut.r_state}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain. It pops words through the FIFO's `r_en`/`empty` interface and presents them downstream as a valid/ready stream through a 2-entry registered skid buffer. Full throughput is one word per cycle, and there is no combinational path from `out_ready` to `fifo_r_en`. A synchronous flush and a handshake counter support drain and debug.

## Interface
- DATA_WIDTH, 8: word width; must match the FIFO's DATA_WIDTH.
- CNT_WIDTH, 16: width of the transfer counter.

- rclk  in  1  read-domain clock; single clock for the whole block.
- rrst_n  in  1  reset, asynchronous assert, active-low.
- fifo_empty  in  1  FIFO empty flag (registered in the FIFO, read domain).
- fifo_rdata  in  DATA_WIDTH  FIFO read data; combinational word at the current read pointer, valid whenever fifo_empty=0.
- fifo_r_en  out  1  pop request to the FIFO. A word is consumed at the rclk edge where fifo_r_en=1 and fifo_empty=0.
- flush  in  1  synchronous discard of all buffered words.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  head word, registered.
- xfer_count  out  CNT_WIDTH  number of completed out handshakes, modulo 2^CNT_WIDTH.

## Operation
- Storage is two registers, `head` and `tail`, plus a 2-bit occupancy `cnt` that takes the values 0, 1 or 2. It works as a state machine with states S0, S1 and S2.
- Outputs derived from storage:
  - out_valid = (cnt != 0).
  - out_data = head.
- fifo_r_en = !fifo_empty && (cnt != 2) && !flush && rrst_n. It depends only on state, fifo_empty and flush, never on out_ready.
- Event definitions:
  - pop = fifo_r_en. fifo_rdata is captured at that edge.
  - deq = out_valid && out_ready.
- Transitions when flush=0:
  - S0: pop → S1, head ← rdata. No pop → stay in S0.
  - S1, pop and deq → stay in S1, head ← rdata.
  - S1, pop only → S2, tail ← rdata.
  - S1, deq only → S0.
  - S1, neither → hold.
  - S2 (pop impossible), deq → S1, head ← tail.
  - S2, no deq → hold.
- flush=1: next state is S0 and fifo_r_en is 0 in that cycle.
  - flush beats a simultaneous deq: the deq still counts in xfer_count, but its word is dropped along with the rest.
  - flush does not empty the FIFO. Draining resumes the cycle after flush deasserts.
- Stream rules:
  - Words leave in FIFO order with no duplication or loss, except on flush.
  - Once out_valid=1, out_valid and out_data stay stable until deq or flush.
- xfer_count increments by 1 on every deq and wraps from 2^CNT_WIDTH−1 to 0. flush does not clear it; only reset does.
- Vacated data registers keep their old values; only out_valid is meaningful.

## Timing
- Reset (rrst_n=0, asynchronous):
  - cnt=0, head=0, tail=0, out_valid=0, out_data=0, xfer_count=0.
  - fifo_r_en=0 while reset is asserted.
- Reset mid-operation discards buffered words. Words already popped from the FIFO are lost. Release is synchronous to rclk through the FIFO's own reset handling.
- Latency: a word present at the FIFO (fifo_empty=0) with S0 or S1 is popped at edge N, and out_valid=1 with that word from edge N onward.
- Throughput: with the FIFO non-empty and out_ready held at 1, there is one pop and one deq per cycle in steady state S1.
- Backpressure:
  - out_ready=0 fills the buffer to S2 after at most 2 pops, then fifo_r_en=0.
  - When out_ready returns, the first deq moves S2→S1, and pops resume in the next cycle.
- FIFO going empty: fifo_r_en drops in the same cycle as fifo_empty. Buffered words still drain downstream.

## Test plan
- Reset and idle:
  - Assert rrst_n=0 with fifo_empty=0 → fifo_r_en=0, out_valid=0, out_data=0, xfer_count=0.
  - Release with fifo_empty=1 → fifo_r_en stays 0.
- Streaming:
  - FIFO holds 0x01..0x08, out_ready=1 → 8 pops in 8 consecutive cycles.
  - out_data sequence is 0x01..0x08, one word per cycle after 1 cycle of latency.
  - xfer_count=8 at the end; out_valid=0 once the FIFO is empty.
- Backpressure:
  - FIFO holds 0xA0..0xA5 and out_ready=0 → exactly 2 pops, cnt=2, out_data=0xA0 held stable, fifo_r_en=0.
  - Then out_ready=1 → 0xA0..0xA5 delivered in order with none lost.
- Random ready:
  - 200 words, out_ready toggled pseudo-randomly, fifo_empty randomly asserted.
  - The output sequence must equal the pop sequence.
  - fifo_r_en must never be 1 while fifo_empty=1 or cnt=2.
- Flush:
  - In S2 holding 0x11 and 0x22, pulse flush with out_ready=1 → next cycle out_valid=0, no pop during the flush cycle, xfer_count +1.
  - The next word delivered is the FIFO's following word, 0x33.
- Counter wrap and mid-run reset:
  - CNT_WIDTH=4, 17 transfers → xfer_count=1.
  - Assert rrst_n mid-stream in S2 → all outputs return to reset values immediately, without waiting for a clock edge.
